// File: rtl/pattern_decoder_pkg.sv
// Shared constants and entry-unpacking helper for the sparse pattern decoder.
package pattern_decoder_pkg;

  localparam logic [3:0] OP_END      = 4'h0;
  localparam logic [3:0] OP_COL_STEP = 4'h1;
  localparam logic [3:0] OP_COL_JUMP = 4'h2;
  localparam logic [3:0] OP_ROW_STEP = 4'h3;

  // Header word positions holding the code-section byte offsets
  localparam int HDR_CODE_START = 2;
  localparam int HDR_CODE_END   = 3;

  // Entry field placement inside a 64-bit stream word
  localparam int OP_LSB  = 0;
  localparam int OP_W    = 4;
  localparam int IMM_LSB = 4;
  localparam int IMM_W   = 6;
  localparam int ARG_LSB = 32;
  localparam int ARG_W   = 32;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [IMM_W-1:0] imm;
    logic [ARG_W-1:0] arg;
  } entry_t;

  function automatic entry_t unpack_entry(input logic [63:0] w);
    entry_t e;
    e.op  = w[OP_LSB  +: OP_W];
    e.imm = w[IMM_LSB +: IMM_W];
    e.arg = w[ARG_LSB +: ARG_W];
    return e;
  endfunction

endpackage

// File: rtl/pattern_reorder_buf.sv
// Tag-indexed response store: written by tag, read at the issue-order pointer.
// A response landing on the slot being read is forwarded in the same cycle.
module pattern_reorder_buf #(
  parameter int TAG_COUNT  = 4,
  parameter int DATA_WIDTH = 64,
  localparam int TAG_WIDTH = $clog2(TAG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [TAG_WIDTH-1:0]  wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [TAG_WIDTH-1:0]  rd_tag,
  input  logic                  pop,
  input  logic                  flush,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [TAG_COUNT-1:0]  slot_valid
);

  logic [DATA_WIDTH-1:0] mem [TAG_COUNT];
  logic                  bypass;

  assign bypass   = wr_en && (wr_tag == rd_tag);
  assign rd_valid = slot_valid[rd_tag] || bypass;
  assign rd_data  = bypass ? wr_data : mem[rd_tag];

  // Slot payload capture; contents are only trusted while the slot is valid
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_tag] <= wr_data;
  end

  // Per-slot valid bits; a pop on the same slot as a write wins (bypass consume)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid <= '0;
    end else if (flush) begin
      slot_valid <= '0;
    end else begin
      if (wr_en) slot_valid[wr_tag] <= 1'b1;
      if (pop)   slot_valid[rd_tag] <= 1'b0;
    end
  end

endmodule

// File: rtl/pattern_decoder.sv
// Sparse-matrix pattern stream decoder: fetches header and code words with
// tagged reads, reorders responses, and emits (row, col) pairs.
//
// state   | meaning
// IDLE    | waiting for start
// HDR     | fetching header words base+0..3, capturing code pointers
// STREAM  | fetching and decoding code words
// DRAIN   | no new requests; discard responses until all tags return
module pattern_decoder
  import pattern_decoder_pkg::*;
#(
  parameter int INDEX_WIDTH = 32,
  parameter int ADDR_WIDTH  = 48,
  parameter int DATA_WIDTH  = 64,
  parameter int TAG_COUNT   = 4,
  localparam int TAG_WIDTH  = $clog2(TAG_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [TAG_WIDTH-1:0]   push_tag,
  input  logic [DATA_WIDTH-1:0]  data,
  output logic                   req,
  input  logic                   req_stall,
  output logic [TAG_WIDTH-1:0]   req_tag,
  output logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  start_addr,
  output logic                   index_push,
  output logic [INDEX_WIDTH-1:0] row,
  output logic [INDEX_WIDTH-1:0] col
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HDR    = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] base, lim_addr, iss_addr, cons_addr, code_start;
  logic [ADDR_WIDTH-1:0] hdr_off, code_end_w;
  logic [TAG_WIDTH-1:0]  iss_tag, cons_tag;
  logic [1:0]            hdr_idx;
  logic [TAG_COUNT-1:0]  busy, busy_set, busy_clr, slot_valid;
  logic                  issuing, present, consume, wr_en, tag_on_bus;
  logic                  rd_valid, start_go, hdr_done;
  logic [DATA_WIDTH-1:0] rd_data;
  entry_t                ent;

  function automatic logic [TAG_WIDTH-1:0] next_tag(input logic [TAG_WIDTH-1:0] t);
    return (t == TAG_WIDTH'(TAG_COUNT - 1)) ? '0 : t + 1'b1;
  endfunction

  assign issuing    = (state == S_HDR) || (state == S_STREAM);
  // A slot is reserved as soon as its request is presented, so the
  // outstanding count can never exceed TAG_COUNT even under stall.
  assign present    = issuing && (!req || !req_stall) && (iss_addr < lim_addr) && !busy[iss_tag];
  assign consume    = issuing && rd_valid;
  // The tag sitting unaccepted on the bus has no read in flight yet
  assign tag_on_bus = req && (req_tag == push_tag);
  assign wr_en      = push && busy[push_tag] && !slot_valid[push_tag] && !tag_on_bus
                      && (state != S_DRAIN);
  assign hdr_off    = rd_data[ADDR_WIDTH+2:3];
  assign code_end_w = base + hdr_off;
  assign ent        = unpack_entry(rd_data);
  assign start_go   = (state == S_IDLE) && start;
  assign hdr_done   = (state == S_HDR) && consume && (hdr_idx == 2'(HDR_CODE_END));

  pattern_reorder_buf #(
    .TAG_COUNT (TAG_COUNT),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rob (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_tag    (push_tag),
    .wr_data   (data),
    .rd_tag    (cons_tag),
    .pop       (consume),
    .flush     (state == S_DRAIN),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .slot_valid(slot_valid)
  );

  // Slot reservation and release masks for this cycle
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (present) busy_set[iss_tag] = 1'b1;
    if (consume) busy_clr[cons_tag] = 1'b1;
    if (state == S_DRAIN) begin
      busy_clr = busy_clr | slot_valid;
      if (push && !tag_on_bus) busy_clr[push_tag] = 1'b1;
    end
  end

  // Request channel: present the next read, hold it stable while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req      <= 1'b0;
      req_tag  <= '0;
      req_addr <= '0;
      iss_tag  <= '0;
      iss_addr <= '0;
      busy     <= '0;
    end else begin
      busy <= (busy | busy_set) & ~busy_clr;
      if (present) begin
        req      <= 1'b1;
        req_tag  <= iss_tag;
        req_addr <= iss_addr;
        iss_tag  <= next_tag(iss_tag);
      end else if (!req_stall) begin
        req <= 1'b0;
      end
      if (start_go)      iss_addr <= start_addr;
      else if (hdr_done) iss_addr <= code_start;
      else if (present)  iss_addr <= iss_addr + ADDR_WIDTH'(1);
    end
  end

  // Sequencing FSM, header capture and entry decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      base       <= '0;
      lim_addr   <= '0;
      code_start <= '0;
      cons_addr  <= '0;
      cons_tag   <= '0;
      hdr_idx    <= '0;
      index_push <= 1'b0;
      row        <= '0;
      col        <= '0;
    end else begin
      index_push <= 1'b0;
      if (consume) cons_tag <= next_tag(cons_tag);
      case (state)
        S_IDLE: begin
          if (start) begin
            base     <= start_addr;
            lim_addr <= start_addr + ADDR_WIDTH'(4);
            hdr_idx  <= '0;
            row      <= '0;
            col      <= '0;
            state    <= S_HDR;
          end
        end
        S_HDR: begin
          if (consume) begin
            hdr_idx <= hdr_idx + 2'd1;
            if (hdr_idx == 2'(HDR_CODE_START)) code_start <= base + hdr_off;
            if (hdr_done) begin
              lim_addr  <= code_end_w;
              cons_addr <= code_start;
              state     <= (code_end_w <= code_start) ? S_DRAIN : S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (consume) begin
            cons_addr <= cons_addr + ADDR_WIDTH'(1);
            case (ent.op)
              OP_COL_STEP: begin
                col        <= col + INDEX_WIDTH'(ent.imm);
                index_push <= 1'b1;
              end
              OP_COL_JUMP: begin
                col        <= col + INDEX_WIDTH'(ent.arg);
                index_push <= 1'b1;
              end
              OP_ROW_STEP: begin
                row        <= row + INDEX_WIDTH'(ent.imm);
                col        <= INDEX_WIDTH'(ent.arg);
                index_push <= 1'b1;
              end
              default: ;
            endcase
            if ((ent.op == OP_END) || (cons_addr + ADDR_WIDTH'(1) == lim_addr)) state <= S_DRAIN;
          end
        end
        default: begin
          // Reads discarded here never advanced the consume pointer; realign it
          if ((busy == '0) && !req) begin
            cons_tag <= iss_tag;
            state    <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_decoder.sv
module tb_pattern_decoder;
  localparam int IW = 32;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int TC = 4;
  localparam int TW = 2;

  logic          clk = 1'b0, rst = 1'b0, push = 1'b0, req_stall = 1'b0, start = 1'b0;
  logic [TW-1:0] push_tag = '0;
  logic [DW-1:0] data = '0;
  logic [AW-1:0] start_addr = '0;
  logic          req, index_push;
  logic [TW-1:0] req_tag;
  logic [AW-1:0] req_addr;
  logic [IW-1:0] row, col;

  always #5 clk = ~clk;

  pattern_decoder dut (
    .clk(clk), .rst(rst), .push(push), .push_tag(push_tag), .data(data),
    .req(req), .req_stall(req_stall), .req_tag(req_tag), .req_addr(req_addr),
    .start(start), .start_addr(start_addr), .index_push(index_push),
    .row(row), .col(col)
  );

  typedef struct { int tag; int addr; } rq_t;

  logic [63:0]   mem [0:511];
  int            n_checks = 0, n_pass = 0;
  rq_t           pend[$];
  int            exp_addr[$];
  logic [IW-1:0] exp_row[$], exp_col[$];
  int            resp_mode = 0, stall_mode = 0, stall_cnt = 0, stall_at = 0;
  bit            stall_fired = 0, rev_drain = 0, prev_stalled = 0;
  int            acc_count = 0, tag_ctr = 0, idle_cnt = 0;
  logic [TW-1:0] prev_tag;
  logic [AW-1:0] prev_addr;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] ent(int op, int imm, logic [31:0] arg);
    return {arg, 22'd0, 6'(imm), 4'(op)};
  endfunction

  task automatic push_exp(logic [IW-1:0] r, logic [IW-1:0] c);
    exp_row.push_back(r);
    exp_col.push_back(c);
  endtask

  // Reference: walk code words with the entry rules, independent of any pipeline
  task automatic model(int cs, int ce);
    logic [31:0] r, c;
    logic [63:0] w;
    logic [3:0]  op;
    r = 0;
    c = 0;
    for (int a = cs; a < ce; a++) begin
      w  = mem[a];
      op = w[3:0];
      if (op == 4'h0) break;
      case (op)
        4'h1: begin c = c + 32'(w[9:4]); push_exp(r, c); end
        4'h2: begin c = c + w[63:32];    push_exp(r, c); end
        4'h3: begin r = r + 32'(w[9:4]); c = w[63:32]; push_exp(r, c); end
        default: ;
      endcase
    end
  endtask

  // Memory responder, stall driver and request checker
  always @(negedge clk) begin
    rq_t r;
    bit  go;
    int  k;
    if (!rst) begin
      push = 1'b0;
      pend.delete();
      prev_stalled = 0;
    end else begin
      go   = 0;
      push = 1'b0;
      if (pend.size() > 0) begin
        case (resp_mode)
          0: begin r = pend.pop_front(); go = 1; end
          1: if (rev_drain || pend.size() >= TC || idle_cnt >= 3) begin
               rev_drain = 1; r = pend.pop_back(); go = 1;
             end
          default: if ($urandom_range(0, 2) != 0) begin
               k = $urandom_range(0, pend.size() - 1);
               r = pend[k]; pend.delete(k); go = 1;
             end
        endcase
      end
      if (pend.size() == 0) rev_drain = 0;
      if (go) begin
        push = 1'b1; push_tag = TW'(r.tag); data = mem[r.addr];
      end
      if (prev_stalled) begin
        check("stall_req", 64'(req), 64'd1);
        check("stall_tag", 64'(req_tag), 64'(prev_tag));
        check("stall_addr", 64'(req_addr), 64'(prev_addr));
      end
      case (stall_mode)
        1: req_stall = ($urandom_range(0, 3) == 0);
        2: if (stall_cnt > 0) begin
             req_stall = 1'b1; stall_cnt--;
           end else if (!stall_fired && req && req_addr == AW'(stall_at)) begin
             stall_fired = 1; req_stall = 1'b1; stall_cnt = 4;
           end else req_stall = 1'b0;
        default: req_stall = 1'b0;
      endcase
      prev_stalled = req && req_stall;
      prev_tag = req_tag;
      prev_addr = req_addr;
      if (req && !req_stall) begin
        if (exp_addr.size() == 0) begin
          n_checks++;
          $display("FAIL extra_req: got addr 0x%0h expected no request", req_addr);
        end else check("req_addr", 64'(req_addr), 64'(exp_addr.pop_front()));
        check("req_tag", 64'(req_tag), 64'(tag_ctr % TC));
        tag_ctr++;
        acc_count++;
        r.tag = int'(req_tag);
        r.addr = int'(req_addr[8:0]);
        pend.push_back(r);
        check("outstanding_le_4", 64'(pend.size() <= TC), 64'd1);
        idle_cnt = 0;
      end else idle_cnt++;
    end
  end

  // Index scoreboard monitor
  always @(negedge clk) begin
    if (rst && index_push) begin
      if (exp_row.size() == 0) begin
        n_checks++;
        $display("FAIL extra_index: got (0x%0h,0x%0h) expected none", row, col);
      end else begin
        check("row", 64'(row), 64'(exp_row.pop_front()));
        check("col", 64'(col), 64'(exp_col.pop_front()));
      end
    end
  end

  task automatic run(int base, int rmode, int smode, int sat, bit use_model);
    int cs, ce, min_req, quiet, full_req;
    bit done, hit_end;
    resp_mode = rmode; stall_mode = smode; stall_at = sat;
    stall_fired = 0; stall_cnt = 0;
    cs = base + int'(mem[base+2] >> 3);
    ce = base + int'(mem[base+3] >> 3);
    exp_addr.delete();
    for (int i = 0; i < 4; i++) exp_addr.push_back(base + i);
    min_req = 4;
    hit_end = 0;
    for (int a = cs; a < ce; a++) begin
      exp_addr.push_back(a);
      if (!hit_end) min_req++;
      if (mem[a][3:0] == 4'h0) hit_end = 1;
    end
    full_req = exp_addr.size();
    if (use_model) model(cs, ce);
    acc_count = 0;
    @(negedge clk); start = 1'b1; start_addr = AW'(base);
    @(negedge clk); start = 1'b0;
    quiet = 0; done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (!req && pend.size() == 0 && exp_row.size() == 0) quiet++;
      else quiet = 0;
      if (quiet >= 8) done = 1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL run_timeout: got no completion expected completion within 3000 cycles");
    end
    check("req_count_min", 64'(acc_count >= min_req), 64'd1);
    if (min_req == full_req) check("req_left", 64'(exp_addr.size()), 64'd0);
    check("idx_left", 64'(exp_row.size()), 64'd0);
    exp_row.delete(); exp_col.delete();
    stall_mode = 0; req_stall = 1'b0;
  endtask

  task automatic load_basic(int b);
    for (int i = 0; i < 16; i++) mem[b+i] = {$urandom, $urandom};
    mem[b+2] = 64'd56;
    mem[b+3] = 64'd80;
    mem[b+7] = ent(3, 0, 32'd5);
    mem[b+8] = ent(1, 3, 32'd0);
    mem[b+9] = ent(3, 2, 32'd1);
  endtask

  task automatic gen_random(output int base);
    int k, len, sel, op;
    base = $urandom_range(0, 200);
    for (int i = 0; i < 4; i++) mem[base+i] = {$urandom, $urandom};
    k   = $urandom_range(4, 20);
    len = $urandom_range(0, 12);
    mem[base+2] = 64'(8 * k + $urandom_range(0, 7));
    if ($urandom_range(0, 7) == 0) mem[base+3] = 64'(8 * $urandom_range(0, k) + $urandom_range(0, 7));
    else mem[base+3] = 64'(8 * (k + len) + $urandom_range(0, 7));
    for (int j = 0; j < len; j++) begin
      sel = $urandom_range(0, 15);
      op  = (sel == 0) ? 0 : (sel <= 4) ? 1 : (sel <= 8) ? 2 : (sel <= 12) ? 3 : $urandom_range(4, 15);
      mem[base+k+j] = {$urandom, 22'($urandom), 6'($urandom), 4'(op)};
    end
  endtask

  initial begin
    int b;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", 64'(req), 64'd0);
    check("rst_req_tag", 64'(req_tag), 64'd0);
    check("rst_req_addr", 64'(req_addr), 64'd0);
    check("rst_index_push", 64'(index_push), 64'd0);
    check("rst_row", 64'(row), 64'd0);
    check("rst_col", 64'(col), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // basic in-order
    load_basic(0);
    push_exp(0, 5); push_exp(0, 8); push_exp(2, 1);
    run(0, 0, 0, 0, 0);

    // reversed groups of responses
    push_exp(0, 5); push_exp(0, 8); push_exp(2, 1);
    run(0, 1, 0, 0, 0);

    // 5-cycle stall on the first code-word request
    push_exp(0, 5); push_exp(0, 8); push_exp(2, 1);
    run(0, 0, 2, 7, 0);

    // END mid-stream
    mem[8] = ent(0, 0, 32'd0);
    push_exp(0, 5);
    run(0, 0, 0, 0, 0);

    // offset base with col wrap
    load_basic(100);
    mem[107] = ent(3, 0, 32'd2);
    mem[108] = ent(2, 0, 32'hFFFF_FFFF);
    mem[109] = ent(1, 63, 32'd0);
    push_exp(0, 2); push_exp(0, 1); push_exp(0, 64);
    run(100, 2, 0, 0, 0);

    // randomized streams against the reference model
    for (int t = 0; t < 30; t++) begin
      gen_random(b);
      run(b, $urandom_range(0, 2), $urandom_range(0, 1), 0, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pattern_decoder.md
Name: pattern_decoder

Overview:
Fetches a packed sparse-matrix pattern stream from memory and decodes it into (row, col) index pairs, at most one pair per cycle. Issues tagged word-read requests to a memory port with up to TAG_COUNT reads outstanding. Accepts read responses in any order and reorders them by tag. Sits between the memory request/response interface and the downstream index consumer of the sparse-matrix pipeline.

Parameters:
INDEX_WIDTH, 32, width of row/col outputs
ADDR_WIDTH, 48, width of word address (one address = one DATA_WIDTH word)
DATA_WIDTH, 64, memory word width
TAG_COUNT, 4, maximum outstanding reads
TAG_WIDTH, clog2(TAG_COUNT), tag width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
push  in  1  read response valid
push_tag  in  TAG_WIDTH  tag of the response
data  in  DATA_WIDTH  response word
req  out  1  read request valid
req_stall  in  1  memory cannot accept a request this cycle
req_tag  out  TAG_WIDTH  tag of the request
req_addr  out  ADDR_WIDTH  word address of the request
start  in  1  one-cycle pulse: begin decoding at start_addr
start_addr  in  ADDR_WIDTH  word address of the stream header
index_push  out  1  row/col valid, one-cycle pulse per index
row  out  INDEX_WIDTH  decoded row
col  out  INDEX_WIDTH  decoded col

Behaviour:
- Reset (rst=0): req=0, req_tag=0, req_addr=0, index_push=0, row=0, col=0; FSM to IDLE; all tag slots freed.
- States: IDLE -> HDR -> STREAM -> DRAIN -> IDLE.
- IDLE: on start=1, latch start_addr as base, clear the row/col accumulators and go to HDR. start is ignored in every other state.
- Request handshake: a request is accepted in a cycle where req=1 and req_stall=0. While req_stall=1, req, req_tag and req_addr are held stable.
- Tag allocation: tags are issued round-robin starting at 0. A tag is issued only when its reorder slot is free, so at most TAG_COUNT reads are outstanding.
- HDR: read words base+0 .. base+3.
  - Word 2 is the byte offset of the code section; word 3 is the byte offset of its end. Both are relative to base.
  - code_start = base + hdr[2]/8; code_end = base + hdr[3]/8 (exclusive). Words 0 and 1 are ignored.
  - Once both pointers are captured, go to STREAM.
  - If code_end <= code_start, go straight to DRAIN.
- STREAM: request words code_start .. code_end-1 in ascending order.
- Reordering: responses are written into the slot selected by push_tag. The decoder consumes slots in issue order, one entry per cycle, freeing each slot as it is consumed.
- Entry format: op = data[3:0], imm = data[9:4] (unsigned), arg = data[63:32].
  - op 0x0 END: emit nothing; go to DRAIN.
  - op 0x1 COL_STEP: col += imm; emit.
  - op 0x2 COL_JUMP: col += arg; emit.
  - op 0x3 ROW_STEP: row += imm; col = arg; emit.
  - Other ops: no-op, no emit.
- Arithmetic is modulo 2^INDEX_WIDTH (wrap, no saturation).
- Emit timing: index_push=1 with the updated row/col in the cycle after the entry is consumed. Minimum latency from an in-order push to index_push is 1 cycle.
- Stream end: when the last entry is consumed, go to DRAIN.
- DRAIN: issue no new requests. Accept and discard responses for outstanding tags. When all slots are free, go to IDLE.
- A response for a tag with no outstanding request is ignored.
- A reset asserted mid-operation aborts immediately to the reset state.

Decomposition:
- Shared package: opcode constants (END, COL_STEP, COL_JUMP, ROW_STEP), header word indices (2 and 3), entry field bit positions.
- One sub-module, pattern_reorder_buf: TAG_COUNT x DATA_WIDTH storage with per-slot valid bits, written by tag and read in issue order.
- Request generation and decoding stay in pattern_decoder.

Test Plan:
- Reset: hold rst=0 -> req=0, index_push=0, row=0, col=0.
- Basic stream, in-order responder with 1-cycle latency, start_addr=0:
  - Memory: hdr[2]=56, hdr[3]=80; word7 = op3 imm0 arg5; word8 = op1 imm3; word9 = op3 imm2 arg1.
  - Required requests: addresses 0..3, then 7, 8, 9.
  - Required indices: (0,5), (0,8), (2,1); then return to IDLE.
- Out-of-order: same memory, responder returns each group of 4 tags in reverse order -> identical index sequence and order.
- Stall: req_stall=1 for 5 cycles during STREAM -> req, req_tag and req_addr stay constant; no duplicate request; same output.
- END mid-stream: word8 = op0 -> only (0,5) emitted; outstanding responses discarded; FSM returns to IDLE.
- Offset and wrap: start_addr=100 -> header requests 100..103. An entry with COL_JUMP arg=0xFFFFFFFF applied to col=2 -> col=1.
